uart_mem_loader: RTL and testbench
==================================

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 BASE_ADDR, 16'h0000, memory word address of first loaded word.
REQ-002 MAX_WORDS, 16'd8192, largest accepted word count (DMEM range).
REQ-003 BAUD_DIV, 16'h0145, divisor written to the SPART DB registers at start.
REQ-004 clk  input  1  system clock (50MHz); reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle pulse; begins a load when idle.
REQ-007 busy_o  output  1  high from accepted start until DONE/ERR.
REQ-008 done_o  output  1  one-cycle pulse on successful completion.
REQ-009 err_o  output  1  sticky; set on oversize count; cleared by next accepted start or rst.
REQ-010 iocs_n  output  1  SPART chip select, active low.
REQ-011 iorw_n  output  1  SPART direction: high read, low write.
REQ-012 ioaddr  output  2  SPART register: 00 DBUF, 01 SREG, 10 DBL, 11 DBH.
REQ-013 databus  inout  8  SPART data; driven only when iocs_n=0 and iorw_n=0, else Z.
REQ-014 mem_we_o  output  1  one-cycle memory write strobe.
REQ-015 mem_addr_o  output  16  memory write address.
REQ-016 mem_wdata_o  output  16  memory write data.

Function
REQ-017 States: IDLE, CFG_LO, CFG_HI, POLL, READ, MEMWR, DONE, ERR (+ ECHO_POLL, ECHO_TX under REQ-030).
REQ-018 IDLE: iocs_n=1, iorw_n=1, ioaddr=00, mem_we_o=0; start_i -> CFG_LO; start_i outside IDLE ignored.
REQ-019 CFG_LO/CFG_HI: one cycle each, iocs_n=0, iorw_n=0, ioaddr=10/11, databus=BAUD_DIV[7:0]/[15:8]; CFG_HI -> POLL.
REQ-020 POLL: iocs_n=0, iorw_n=1, ioaddr=01; databus sampled same cycle; SREG[3:0]!=0 -> READ, else stay POLL.
REQ-021 READ: one cycle iocs_n=0, iorw_n=1, ioaddr=00; byte latched at clock edge (exactly one pop per READ).
REQ-022 Stream format: byte0/byte1 = word count N (little-endian), then N words, each low byte then high byte.
REQ-023 After header: N==0 -> DONE; N>MAX_WORDS -> ERR; else next byte -> POLL.
REQ-024 After each word's high byte -> MEMWR: mem_we_o=1 for one cycle, mem_addr_o=BASE_ADDR+k (k=0..N-1, 16-bit wrap), mem_wdata_o={hi,lo}.
REQ-025 MEMWR: k==N-1 -> DONE, else -> POLL; mem_addr_o/mem_wdata_o hold last value otherwise.
REQ-026 DONE: done_o=1 one cycle, busy_o drops same cycle, -> IDLE.
REQ-027 ERR: err_o set, busy_o=0, -> IDLE; no memory writes issued for that load.
REQ-028 Latency: MEMWR occurs exactly 1 cycle after READ of high byte; no stall source besides SREG polling.

Reset
REQ-029 rst at any edge (including mid-load) -> IDLE; iocs_n=1, iorw_n=1, ioaddr=00, databus Z, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0, byte/word counters and checksum cleared.

Configuration
REQ-030 LOADER_ECHO_EN defined: running XOR of all received bytes (header included); before DONE, ECHO_POLL polls SREG until SREG[7:4]!=0, then ECHO_TX one cycle writes checksum to DBUF (iocs_n=0, iorw_n=0, ioaddr=00), then DONE; not defined: no checksum logic, MEMWR/header path goes straight to DONE, ERR never echoes.

Verification
REQ-031 Reset mid-load after 3 bytes -> outputs per REQ-029 next cycle; new start with clean stream loads correctly.
REQ-032 start; stream 02 00 34 12 CD AB -> writes 16'h1234@0000, 16'hABCD@0001, done_o pulse, err_o=0; CFG writes 45 then 01 seen first.
REQ-033 SREG[3:0]=0 for 20 cycles between bytes -> POLL repeated 20 cycles, no READ, no extra pops.
REQ-034 Header 00 00 -> done_o with zero mem_we_o pulses.
REQ-035 Header 01 20 (8193) -> err_o=1, no mem writes; next start clears err_o.
REQ-036 LOADER_ECHO_EN, stream 01 00 FF 0F -> checksum F1 written to DBUF after SREG[7:4]!=0, then done_o.

Source files
------------

// File: rtl/uart_mem_loader_if.sv
// Control, SPART register-access and memory-write signals of uart_mem_loader.
// The SPART databus is bidirectional and stays a plain inout port on the module.
interface uart_mem_loader_if;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        iocs_n;
  logic        iorw_n;
  logic [1:0]  ioaddr;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;

  modport master (
    input  start_i,
    output busy_o, done_o, err_o,
    output iocs_n, iorw_n, ioaddr,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output start_i,
    input  busy_o, done_o, err_o,
    input  iocs_n, iorw_n, ioaddr,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/uart_mem_loader.sv
// Loads a length-prefixed little-endian word stream from a SPART into memory.
// Define LOADER_ECHO_EN to echo the XOR checksum of all received bytes before DONE.
module uart_mem_loader #(
  parameter logic [15:0] BaseAddr = 16'h0000,
  parameter logic [15:0] MaxWords = 16'd8192,
  parameter logic [15:0] BaudDiv  = 16'h0145
) (
  input  logic              clk,
  input  logic              rst,
  uart_mem_loader_if.master bus,
  inout  wire [7:0]         databus
);

  typedef enum logic [3:0] {
    StIdle, StCfgLo, StCfgHi, StPoll, StRead, StMemWr, StDone, StErr
`ifdef LOADER_ECHO_EN
    , StEchoPoll, StEchoTx
`endif
  } state_e;

`ifdef LOADER_ECHO_EN
  localparam state_e StFinish = StEchoPoll;
`else
  localparam state_e StFinish = StDone;
`endif

  state_e      state_q, state_d;
  logic        hdr_q, hdr_d;        // still receiving the word-count header
  logic        hi_q, hi_d;          // next byte is the high byte of a pair
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] k_q, k_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
`ifdef LOADER_ECHO_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        iocs_n, iorw_n, mem_we, done, busy, drive;
  logic [1:0]  ioaddr;
  logic [7:0]  dout;
  logic [7:0]  rx_byte;
  logic [15:0] hdr_n;

  assign rx_byte = databus;
  assign hdr_n   = {rx_byte, cnt_lo_q};

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hi_d        = hi_q;
    cnt_lo_d    = cnt_lo_q;
    n_d         = n_q;
    k_d         = k_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
`ifdef LOADER_ECHO_EN
    chk_d       = chk_q;
`endif
    iocs_n = 1'b1;
    iorw_n = 1'b1;
    ioaddr = 2'b00;
    drive  = 1'b0;
    dout   = 8'h00;
    mem_we = 1'b0;
    done   = 1'b0;
    busy   = 1'b1;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (bus.start_i) begin
          state_d = StCfgLo;
          err_d   = 1'b0;
          hdr_d   = 1'b1;
          hi_d    = 1'b0;
          k_d     = 16'h0000;
`ifdef LOADER_ECHO_EN
          chk_d   = 8'h00;
`endif
        end
      end
      StCfgLo: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = 2'b10;
        drive   = 1'b1;
        dout    = BaudDiv[7:0];
        state_d = StCfgHi;
      end
      StCfgHi: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = 2'b11;
        drive   = 1'b1;
        dout    = BaudDiv[15:8];
        state_d = StPoll;
      end
      StPoll: begin
        iocs_n = 1'b0;
        ioaddr = 2'b01;
        if (rx_byte[3:0] != 4'h0) state_d = StRead;
      end
      StRead: begin
        iocs_n = 1'b0;
        ioaddr = 2'b00;
        hi_d   = ~hi_q;
`ifdef LOADER_ECHO_EN
        chk_d  = chk_q ^ rx_byte;
`endif
        if (!hi_q) begin
          if (hdr_q) cnt_lo_d = rx_byte;
          else       lo_d     = rx_byte;
          state_d = StPoll;
        end else if (hdr_q) begin
          n_d   = hdr_n;
          hdr_d = 1'b0;
          if (hdr_n == 16'h0000) begin
            state_d = StFinish;
          end else if (hdr_n > MaxWords) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StPoll;
          end
        end else begin
          // Address/data are registered here so they hold between strobes.
          mem_addr_d  = BaseAddr + k_q;
          mem_wdata_d = {rx_byte, lo_q};
          state_d     = StMemWr;
        end
      end
      StMemWr: begin
        mem_we  = 1'b1;
        k_d     = k_q + 16'h0001;
        state_d = (k_q == n_q - 16'h0001) ? StFinish : StPoll;
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
`ifdef LOADER_ECHO_EN
      StEchoPoll: begin
        iocs_n = 1'b0;
        ioaddr = 2'b01;
        if (rx_byte[7:4] != 4'h0) state_d = StEchoTx;
      end
      StEchoTx: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = 2'b00;
        drive   = 1'b1;
        dout    = chk_q;
        state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_q       <= 1'b0;
      hi_q        <= 1'b0;
      cnt_lo_q    <= 8'h00;
      n_q         <= 16'h0000;
      k_q         <= 16'h0000;
      lo_q        <= 8'h00;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      err_q       <= 1'b0;
`ifdef LOADER_ECHO_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hi_q        <= hi_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      k_q         <= k_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
`ifdef LOADER_ECHO_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign databus         = drive ? dout : 8'hzz;
  assign bus.iocs_n      = iocs_n;
  assign bus.iorw_n      = iorw_n;
  assign bus.ioaddr      = ioaddr;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized bench for uart_mem_loader with a SPART model and a stream-level reference.
// Build with LOADER_ECHO_EN defined to also check the checksum echo.
module tb_uart_mem_loader;

  localparam logic [15:0] BaseAddr = 16'h0000;
  localparam int          MaxWords = 8192;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  uart_mem_loader_if bus ();
  wire [7:0] databus;

  uart_mem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus)
  );

  // SPART model: receive queue, SREG[3:0] = rx available, SREG[7:4] = tx ready.
  logic [7:0] rx_mem [$];
  int         rd_idx;
  logic       stall, stall_force, tx_rdy;
  int         stall_pct;
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (bus.ioaddr == 2'b01)
      rd_val = {(tx_rdy ? 4'h1 : 4'h0), ((!stall && rd_idx < rx_mem.size()) ? 4'h1 : 4'h0)};
    else if (bus.ioaddr == 2'b00 && rd_idx < rx_mem.size())
      rd_val = rx_mem[rd_idx];
  end

  assign databus = (!bus.iocs_n && bus.iorw_n) ? rd_val : 8'hzz;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem_log [$];
  logic [15:0] io_wr_log [$];
  int          done_cnt, busy_at_done, pops, polls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: observe mid-cycle, then advance the SPART model after the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = !bus.iocs_n && bus.iorw_n && bus.ioaddr == 2'b00;
    if (!bus.iocs_n && bus.iorw_n && bus.ioaddr == 2'b01) polls++;
    if (!bus.iocs_n && !bus.iorw_n) io_wr_log.push_back({6'b0, bus.ioaddr, databus});
    if (bus.mem_we_o) mem_log.push_back({bus.mem_addr_o, bus.mem_wdata_o});
    if (bus.done_o) begin
      done_cnt++;
      if (bus.busy_o) busy_at_done++;
    end
    @(posedge clk);
    #1;
    if (pop && !rst) begin
      rd_idx++;
      pops++;
    end
    stall  = stall_force || ($urandom_range(0, 99) < stall_pct);
    tx_rdy = ($urandom_range(0, 1) == 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_iocs_n"},  {31'b0, bus.iocs_n}, 32'd1);
    check_eq({tag, "_iorw_n"},  {31'b0, bus.iorw_n}, 32'd1);
    check_eq({tag, "_ioaddr"},  {30'b0, bus.ioaddr}, 32'd0);
    check_eq({tag, "_mem_we"},  {31'b0, bus.mem_we_o}, 32'd0);
    check_eq({tag, "_mem_addr"}, {16'b0, bus.mem_addr_o}, 32'd0);
    check_eq({tag, "_mem_wdata"}, {16'b0, bus.mem_wdata_o}, 32'd0);
    check_eq({tag, "_busy"},    {31'b0, bus.busy_o}, 32'd0);
    check_eq({tag, "_done"},    {31'b0, bus.done_o}, 32'd0);
    check_eq({tag, "_err"},     {31'b0, bus.err_o}, 32'd0);
  endtask

  task automatic start_load(input logic [7:0] s [$]);
    rx_mem = s;
    rd_idx = 0;
    pops = 0;
    polls = 0;
    done_cnt = 0;
    busy_at_done = 0;
    mem_log.delete();
    io_wr_log.delete();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    check_eq("busy_after_start", {31'b0, bus.busy_o}, 32'd1);
    check_eq("err_clr_on_start", {31'b0, bus.err_o}, 32'd0);
  endtask

  // Full load compared against what the byte stream alone implies.
  task automatic run_load(input string tag, input logic [7:0] s [$], input int hold_at);
    int          n, exp_pops, cycles, p0, q0;
    logic        exp_err, finished, held;
    logic [7:0]  chk;
    logic [31:0] exp_w;
    n = {s[1], s[0]};
    exp_err = (n > MaxWords);
    exp_pops = exp_err ? 2 : 2 + 2 * n;
    chk = 8'h00;
    for (int i = 0; i < exp_pops; i++) chk ^= s[i];
    start_load(s);
    finished = 1'b0;
    held = 1'b0;
    cycles = 0;
    while (!finished && cycles < 5000) begin
      if (hold_at >= 0 && !held && rd_idx == hold_at) begin
        stall_force = 1'b1;
        stall = 1'b1;
        p0 = pops;
        q0 = polls;
        repeat (20) step();
        stall_force = 1'b0;
        held = 1'b1;
        check_eq({tag, "_hold_pops"}, pops - p0, 32'd0);
        check_eq({tag, "_hold_polls"}, polls - q0, 32'd20);
      end
      // Stray starts mid-load must be ignored.
      bus.start_i = ($urandom_range(0, 15) == 0);
      step();
      bus.start_i = 1'b0;
      cycles++;
      if (bus.done_o || bus.err_o) finished = 1'b1;
    end
    if (!finished) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    step();
    check_eq({tag, "_done_cnt"}, done_cnt, exp_err ? 32'd0 : 32'd1);
    check_eq({tag, "_err"}, {31'b0, bus.err_o}, {31'b0, exp_err});
    check_eq({tag, "_busy_at_done"}, busy_at_done, 32'd0);
    check_eq({tag, "_busy_end"}, {31'b0, bus.busy_o}, 32'd0);
    check_eq({tag, "_pops"}, pops, exp_pops);
    check_eq({tag, "_nwrites"}, mem_log.size(), exp_err ? 32'd0 : n);
    for (int k = 0; k < mem_log.size() && k < n; k++) begin
      exp_w = {BaseAddr + 16'(k), s[3 + 2 * k], s[2 + 2 * k]};
      check_eq({tag, "_memwr"}, mem_log[k], exp_w);
    end
    if (io_wr_log.size() >= 2) begin
      check_eq({tag, "_cfg_lo"}, {16'b0, io_wr_log[0]}, 32'h0245);
      check_eq({tag, "_cfg_hi"}, {16'b0, io_wr_log[1]}, 32'h0301);
    end
`ifdef LOADER_ECHO_EN
    check_eq({tag, "_io_writes"}, io_wr_log.size(), exp_err ? 32'd2 : 32'd3);
    if (!exp_err && io_wr_log.size() == 3)
      check_eq({tag, "_echo"}, {16'b0, io_wr_log[2]}, {24'h0, chk});
`else
    check_eq({tag, "_io_writes"}, io_wr_log.size(), 32'd2);
`endif
  endtask

  task automatic run_partial(input string tag, input logic [7:0] s [$], input int nbytes);
    int cycles;
    start_load(s);
    cycles = 0;
    while (rd_idx < nbytes && cycles < 2000) begin
      step();
      cycles++;
    end
    if (rd_idx < nbytes) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [7:0] s [$];
    int         n;
    rst = 1'b1;
    bus.start_i = 1'b0;
    stall = 1'b0;
    stall_force = 1'b0;
    stall_pct = 0;
    tx_rdy = 1'b1;
    rx_mem = {};
    rd_idx = 0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    run_load("two_words", s, -1);
    run_load("hold20", s, 3);

    s = '{8'h00, 8'h00};
    run_load("empty", s, -1);

    s = '{8'h01, 8'h20};
    run_load("oversize", s, -1);
    repeat (5) step();
    check_eq("err_sticky", {31'b0, bus.err_o}, 32'd1);

    s = '{8'h01, 8'h00, 8'hFF, 8'h0F};
    run_load("one_word", s, -1);

    stall_pct = 30;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 6);
      s = '{8'(n), 8'h00};
      for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
      run_load("rand", s, (t % 3 == 0) ? 2 + 2 * $urandom_range(0, n - 1) + 1 : -1);
    end

    n = $urandom_range(MaxWords + 1, 65535);
    s = '{8'(n), 8'(n >> 8)};
    run_load("rand_oversize", s, -1);

    // Reset after three bytes of a load.
    s = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_partial("midload", s, 3);
    rst = 1'b1;
    step();
    check_reset_state("midload_rst");
    rst = 1'b0;
    step();
    run_load("after_rst", s, -1);

    // Exactly MaxWords is accepted; abandon it after the first word.
    s = '{8'h00, 8'h20, 8'hA5, 8'h5A};
    run_partial("maxwords", s, 4);
    step();
    step();
    check_eq("maxwords_err", {31'b0, bus.err_o}, 32'd0);
    check_eq("maxwords_busy", {31'b0, bus.busy_o}, 32'd1);
    check_eq("maxwords_wr", mem_log.size(), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
